// File: rtl/alarm_handler.sv
// Alarm session FSM: turns the alarm generator's match level into ring/irq/snooze/missed outputs.
// Optional build macro ALARM_AUTO_SNOOZE_EN: a ring timeout spends a snooze instead of ending.
module alarm_handler #(
  parameter int unsigned SNOOZE_W     = 16,
  parameter int unsigned MAX_SNOOZE   = 3,
  parameter int unsigned RING_TIMEOUT = 1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                alarm_i,
  input  logic                stop_req_i,
  input  logic                snooze_req_i,
  input  logic [SNOOZE_W-1:0] snooze_len_i,
  input  logic                clr_missed_i,
  output logic                ring_o,
  output logic                irq_o,
  output logic                snooze_active_o,
  output logic [3:0]          snooze_cnt_o,
  output logic                missed_o
);

  localparam int unsigned RingW = $clog2(RING_TIMEOUT);
  localparam logic [RingW-1:0] RingLast = RingW'(RING_TIMEOUT - 1);
  localparam logic [3:0] MaxSnz = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

  state_e              state_q, state_d;
  logic                alarm_q;
  logic [RingW-1:0]    ring_tmr_q, ring_tmr_d;
  logic [SNOOZE_W-1:0] snz_tmr_q, snz_tmr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                missed_q, missed_d;
  logic                irq_q, irq_d;

  logic                rise;
  logic                go_idle;
  logic                go_snooze;
  logic                budget_left;
  logic [SNOOZE_W-1:0] snz_len_eff;

  assign rise        = alarm_i & ~alarm_q;
  assign budget_left = (cnt_q < MaxSnz);
  // A zero length would underflow the down-counter, so it is promoted to one cycle.
  assign snz_len_eff = (snooze_len_i == '0) ? SNOOZE_W'(1) : snooze_len_i;

  always_comb begin
    state_d    = state_q;
    ring_tmr_d = ring_tmr_q;
    snz_tmr_d  = snz_tmr_q;
    cnt_d      = cnt_q;
    missed_d   = clr_missed_i ? 1'b0 : missed_q;
    irq_d      = 1'b0;
    go_idle    = 1'b0;
    go_snooze  = 1'b0;

    case (state_q)
      StIdle: begin
        if (rise && enable_i) begin
          state_d    = StRing;
          irq_d      = 1'b1;
          ring_tmr_d = '0;
          cnt_d      = '0;
        end
      end
      StRing: begin
        if (!enable_i || stop_req_i) begin
          go_idle = 1'b1;
        end else if (snooze_req_i && budget_left) begin
          go_snooze = 1'b1;
        end else if (ring_tmr_q == RingLast) begin
`ifdef ALARM_AUTO_SNOOZE_EN
          if (budget_left) begin
            go_snooze = 1'b1;
          end else begin
            go_idle  = 1'b1;
            missed_d = 1'b1;
          end
`else
          go_idle  = 1'b1;
          missed_d = 1'b1;
`endif
        end else begin
          ring_tmr_d = ring_tmr_q + RingW'(1);
        end
      end
      StSnooze: begin
        if (!enable_i || stop_req_i) begin
          go_idle = 1'b1;
        end else if (snz_tmr_q == SNOOZE_W'(1)) begin
          state_d    = StRing;
          irq_d      = 1'b1;
          ring_tmr_d = '0;
        end else begin
          snz_tmr_d = snz_tmr_q - SNOOZE_W'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_snooze) begin
      state_d   = StSnooze;
      cnt_d     = cnt_q + 4'd1;
      snz_tmr_d = snz_len_eff;
    end
    if (go_idle) begin
      state_d    = StIdle;
      cnt_d      = '0;
      ring_tmr_d = '0;
      snz_tmr_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      alarm_q    <= 1'b0;
      ring_tmr_q <= '0;
      snz_tmr_q  <= '0;
      cnt_q      <= '0;
      missed_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alarm_q    <= alarm_i;
      ring_tmr_q <= ring_tmr_d;
      snz_tmr_q  <= snz_tmr_d;
      cnt_q      <= cnt_d;
      missed_q   <= missed_d;
      irq_q      <= irq_d;
    end
  end

  assign ring_o          = (state_q == StRing);
  assign snooze_active_o = (state_q == StSnooze);
  assign irq_o           = irq_q;
  assign snooze_cnt_o    = cnt_q;
  assign missed_o        = missed_q;

endmodule

// File: tb/tb_alarm_handler.sv
// Scoreboard bench for alarm_handler: each driven cycle queues its expected outputs,
// which are compared against the sampled outputs at the end of every scenario.
module tb_alarm_handler;
  localparam int unsigned SnoozeW     = 16;
  localparam int unsigned MaxSnooze   = 3;
  localparam int unsigned RingTimeout = 8;
`ifdef ALARM_AUTO_SNOOZE_EN
  localparam int AutoMax = MaxSnooze;
`else
  localparam int AutoMax = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_i, enable_i, alarm_i, stop_req_i, snooze_req_i, clr_missed_i;
  logic [SnoozeW-1:0] snooze_len_i;
  logic               ring_o, irq_o, snooze_active_o, missed_o;
  logic [3:0]         snooze_cnt_o;

  typedef logic [7:0] vec_t;  // {ring, irq, snooze_active, snooze_cnt[3:0], missed}

  vec_t  exp_q[$];
  vec_t  got_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    errors  = 0;

  always #5 clk = ~clk;

  alarm_handler #(
    .SNOOZE_W    (SnoozeW),
    .MAX_SNOOZE  (MaxSnooze),
    .RING_TIMEOUT(RingTimeout)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .alarm_i        (alarm_i),
    .stop_req_i     (stop_req_i),
    .snooze_req_i   (snooze_req_i),
    .snooze_len_i   (snooze_len_i),
    .clr_missed_i   (clr_missed_i),
    .ring_o         (ring_o),
    .irq_o          (irq_o),
    .snooze_active_o(snooze_active_o),
    .snooze_cnt_o   (snooze_cnt_o),
    .missed_o       (missed_o)
  );

  function automatic vec_t mk(input logic r, input logic i, input logic s, input logic [3:0] c,
                              input logic m);
    return {r, i, s, c, m};
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, sample after the edge.
  task automatic apply(input logic a_al, input logic a_st, input logic a_sn,
                       input logic [SnoozeW-1:0] a_len, input logic a_clr, input logic a_en,
                       input logic a_rst, input vec_t e, input string tag);
    alarm_i      = a_al;
    stop_req_i   = a_st;
    snooze_req_i = a_sn;
    snooze_len_i = a_len;
    clr_missed_i = a_clr;
    enable_i     = a_en;
    rst_i        = a_rst;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got_q.push_back({ring_o, irq_o, snooze_active_o, snooze_cnt_o, missed_o});
  endtask

  task automatic test_reset();
    vec_t e, g;
    string t;
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 4'd0, 0), "reset");
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 4'd0, 0), "reset_alarm_high");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "post_reset_idle");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: ring,irq,snz,cnt,missed got %b required %b", t, g, e);
      end
    end
  endtask

  task automatic test_ring_stop();
    vec_t e, g;
    string t;
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "ring_entry_irq");
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd0, 0), "held_alarm_no_irq");
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd0, 0), "held_alarm_no_irq");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd0, 0), "ring_hold");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd0, 0), "ring_hold");
    apply(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "stop");
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "ring_entry_irq");
    apply(1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "stop_beats_snooze");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "idle_after_stop");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: ring,irq,snz,cnt,missed got %b required %b", t, g, e);
      end
    end
  endtask

  task automatic test_snooze_limit();
    vec_t e, g;
    string t;
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "ring_entry_irq");
    for (int n = 1; n <= int'(MaxSnooze); n++) begin
      apply(1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'(n), 0), "snooze_enter");
      for (int c = 0; c < 4; c++)
        apply(1'b0, 1'b0, 1'b0, 16'd9, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'(n), 0), "snooze_wait");
      apply(1'b0, 1'b0, 1'b0, 16'd9, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'(n), 0), "snooze_expire");
    end
    apply(1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd3, 0), "snooze_exhausted");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd3, 0), "ring_after_ignore");
    apply(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "stop_clears_cnt");
    // A zero length must still give exactly one silent cycle.
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "ring_entry_irq");
    apply(1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'd1, 0), "snooze_len0");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd1, 0), "snooze_len0_expire");
    apply(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "stop");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: ring,irq,snz,cnt,missed got %b required %b", t, g, e);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t e, g;
    string t;
    for (int k = 0; k <= AutoMax; k++) begin
      apply(k == 0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'(k), 0), "timeout_entry");
      for (int c = 1; c < int'(RingTimeout); c++)
        apply(1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'(k), 0), "timeout_ring");
      if (k < AutoMax) begin
        apply(1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'(k + 1), 0), "auto_snooze");
        apply(1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'(k + 1), 0), "auto_snooze");
      end else begin
        apply(1'b0, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 1), "timeout_missed");
      end
    end
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 1), "missed_sticky");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "missed_clear");
`ifndef ALARM_AUTO_SNOOZE_EN
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "timeout_entry");
    for (int c = 1; c < int'(RingTimeout); c++)
      apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd0, 0), "timeout_ring");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 1), "set_beats_clear");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "missed_clear");
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "timeout_entry");
    for (int c = 1; c < int'(RingTimeout); c++)
      apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd0, 0), "timeout_ring");
    apply(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "stop_beats_timeout");
`endif
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: ring,irq,snz,cnt,missed got %b required %b", t, g, e);
      end
    end
  endtask

  task automatic test_interrupts();
    vec_t e, g;
    string t;
    // Reset during snooze.
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "ring_entry_irq");
    apply(1'b0, 1'b0, 1'b1, 16'd5, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'd1, 0), "snooze_enter");
    apply(1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'd1, 0), "snooze_wait");
    apply(1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 4'd0, 0), "rst_in_snooze");
    apply(1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "idle_after_rst");
    // Enable gating.
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 4'd0, 0), "en_low_idle");
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 4'd0, 0), "en_low_rise_dropped");
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "no_spurious_rise");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "idle");
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "rise_after_enable");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 4'd0, 0), "en_drop_ring");
    apply(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "idle");
    // Alarm rises while a session is live are ignored.
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "ring_entry_irq");
    apply(1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'd1, 0), "snooze_enter");
    apply(1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'd1, 0), "snooze_wait");
    apply(1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, mk(0, 0, 1, 4'd1, 0), "rise_in_snooze");
    apply(1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd1, 0), "snooze_expire");
    apply(1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd1, 0), "ring_hold");
    apply(1'b1, 1'b0, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 4'd1, 0), "rise_in_ring");
    apply(1'b0, 1'b1, 1'b0, 16'd3, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "stop");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: ring,irq,snz,cnt,missed got %b required %b", t, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t e, g;
    string t;
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "ring_entry_irq");
    apply(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "stop");
    apply(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(1, 1, 0, 4'd0, 0), "back_to_back_entry");
    apply(1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 4'd0, 0), "stop");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front();
      vectors++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: ring,irq,snz,cnt,missed got %b required %b", t, g, e);
      end
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    enable_i     = 1'b1;
    alarm_i      = 1'b0;
    stop_req_i   = 1'b0;
    snooze_req_i = 1'b0;
    snooze_len_i = '0;
    clr_missed_i = 1'b0;
    test_reset();
    test_ring_stop();
    test_snooze_limit();
    test_timeout();
    test_interrupts();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
